ejection_buffer: RTL and testbench

Flit FIFO that sits directly downstream of the reduction tree and absorbs its single merged flit stream before the ejection/consumer port. It accepts flits on a valid/avail handshake, stores up to `DEPTH` flits in a circular buffer plus one registered output stage, and presents them in order on a second valid/avail handshake. It also reports occupancy, a high-water mark and a sticky protocol-error flag for debug.

---
 rtl/ejection_buffer.sv | 141 ++++++++++++++
 tb/tb_ejection_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ejection_buffer.sv
// ejection_buffer
//   Flit FIFO placed after the reduction tree, ahead of the ejection port.
//   DEPTH circular-buffer entries plus one registered output stage. Both
//   handshakes are register-to-register: in_avail and out_valid come
//   straight from flops.
//
// Optional feature macro: EJECT_BYPASS_EN
//   When defined, a flit arriving while the FIFO is empty and the output
//   register is loading goes straight into the output register, which saves
//   one cycle of latency. Ordering, capacity and debug outputs are the same
//   in both builds.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   in            flit from the upstream tree
//   in_valid      in holds a flit
//   in_avail      buffer can accept a flit (registered)
//   out           head flit (registered)
//   out_valid     out holds a flit (registered)
//   out_avail     consumer accepts the flit
//   occupancy     FIFO entries + out_valid (registered)
//   max_occupancy high-water mark of occupancy, cleared by reset only
//   drop_err      sticky: flit offered while in_avail was low

module ejection_buffer #(
  parameter int DEPTH     = 8,
  parameter int FLIT_SIZE = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int OW = $clog2(DEPTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] in,
  input  logic                 in_valid,
  output logic                 in_avail,
  output logic [FLIT_SIZE-1:0] out,
  output logic                 out_valid,
  input  logic                 out_avail,
  output logic [OW-1:0]        occupancy,
  output logic [OW-1:0]        max_occupancy,
  output logic                 drop_err
);

  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [FLIT_SIZE-1:0] mem_q [DEPTH];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]        fifo_count_q, fifo_count_d;
  logic [FLIT_SIZE-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_avail_q, in_avail_d;
  logic [OW-1:0]        occupancy_q, occupancy_d;
  logic [OW-1:0]        max_occupancy_q, max_occupancy_d;
  logic                 drop_err_q, drop_err_d;

  logic push;
  logic load;
  logic fifo_empty;
  logic bypass;
  logic pop_fifo;
  logic wr_fifo;

  always_comb begin
    push       = in_valid && in_avail_q;
    // Output register takes a new flit when it is empty or being drained.
    load       = !out_valid_q || out_avail;
    fifo_empty = (fifo_count_q == '0);
    bypass     = 1'b0;
`ifdef EJECT_BYPASS_EN
    bypass     = push && load && fifo_empty;
`else
    bypass     = 1'b0;
`endif
    pop_fifo   = load && !fifo_empty;
    wr_fifo    = push && !bypass;

    wr_ptr_d = wr_fifo  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_fifo ? rd_ptr_q + AW'(1) : rd_ptr_q;

    fifo_count_d = fifo_count_q + OW'(wr_fifo) - OW'(pop_fifo);

    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = pop_fifo || bypass;
      if (pop_fifo) begin
        out_d = mem_q[rd_ptr_q];
      end else if (bypass) begin
        out_d = in;
      end
    end

    // Exact next-state count, so a free slot is never refused.
    in_avail_d      = (fifo_count_d < DEPTH_C);
    occupancy_d     = fifo_count_d + OW'(out_valid_d);
    max_occupancy_d = (occupancy_d > max_occupancy_q) ? occupancy_d : max_occupancy_q;
    drop_err_d      = drop_err_q || (in_valid && !in_avail_q);
  end

  // Storage needs no reset: validity is tracked by fifo_count alone.
  always_ff @(posedge clk) begin
    if (wr_fifo) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_count_q    <= '0;
      out_q           <= '0;
      out_valid_q     <= 1'b0;
      in_avail_q      <= 1'b1;
      occupancy_q     <= '0;
      max_occupancy_q <= '0;
      drop_err_q      <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fifo_count_q    <= fifo_count_d;
      out_q           <= out_d;
      out_valid_q     <= out_valid_d;
      in_avail_q      <= in_avail_d;
      occupancy_q     <= occupancy_d;
      max_occupancy_q <= max_occupancy_d;
      drop_err_q      <= drop_err_d;
    end
  end

  assign in_avail      = in_avail_q;
  assign out           = out_q;
  assign out_valid     = out_valid_q;
  assign occupancy     = occupancy_q;
  assign max_occupancy = max_occupancy_q;
  assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_ejection_buffer.sv
// Testbench for ejection_buffer: directed scenarios plus random traffic.
// A queue-based reference model predicts every registered output each cycle;
// a scoreboard records accepted flits and a monitor checks delivered order.
module tb_ejection_buffer;

  localparam int DEPTH = 8;
  localparam int FW    = 8;
  localparam int OW    = $clog2(DEPTH + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] din = '0;
  logic          in_valid = 1'b0;
  logic          in_avail;
  logic [FW-1:0] dout;
  logic          out_valid;
  logic          out_avail = 1'b0;
  logic [OW-1:0] occ;
  logic [OW-1:0] max_occ;
  logic          drop_err;

  ejection_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (din),
    .in_valid     (in_valid),
    .in_avail     (in_avail),
    .out          (dout),
    .out_valid    (out_valid),
    .out_avail    (out_avail),
    .occupancy    (occ),
    .max_occupancy(max_occ),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int delivered = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard of accepted flits, in acceptance order.
  logic [FW-1:0] sb[$];

  // Reference model: a queue for FIFO storage and one output slot.
  logic [FW-1:0] m_fifo[$];
  logic [FW-1:0] m_out;
  bit            m_out_valid;
  bit            m_in_avail;
  int            m_occ;
  int            m_max;
  bit            m_drop;

  task automatic model_reset();
    m_fifo.delete();
    m_out       = '0;
    m_out_valid = 0;
    m_in_avail  = 1;
    m_occ       = 0;
    m_max       = 0;
    m_drop      = 0;
  endtask

  task automatic model_step(input bit v, input logic [FW-1:0] d, input bit oa);
    bit acc;
    bit ld;
    bit byp;
    acc = v && m_in_avail;
    ld  = !m_out_valid || oa;
    byp = 0;
`ifdef EJECT_BYPASS_EN
    byp = acc && ld && (m_fifo.size() == 0);
`endif
    if (v && !m_in_avail) m_drop = 1;
    if (ld) begin
      if (m_fifo.size() > 0) begin
        m_out = m_fifo.pop_front();
        m_out_valid = 1;
      end else if (byp) begin
        m_out = d;
        m_out_valid = 1;
      end else begin
        m_out_valid = 0;
      end
    end
    if (acc && !byp) m_fifo.push_back(d);
    m_in_avail = (m_fifo.size() < DEPTH);
    m_occ = m_fifo.size() + int'(m_out_valid);
    if (m_occ > m_max) m_max = m_occ;
  endtask

  // Model checker: compare DUT to model at negedge, then advance the model.
  initial model_reset();
  always @(negedge clk) begin
    if (!rst) model_reset();
    chk("in_avail",  int'(in_avail),  int'(m_in_avail));
    chk("out_valid", int'(out_valid), int'(m_out_valid));
    chk("out",       int'(dout),      int'(m_out));
    chk("occupancy", int'(occ),       m_occ);
    chk("max_occ",   int'(max_occ),   m_max);
    chk("drop_err",  int'(drop_err),  int'(m_drop));
    if (rst) model_step(in_valid, din, out_avail);
  end

  // Monitor: a drain at the coming edge must deliver the oldest accepted flit.
  always @(negedge clk) begin
    if (rst && out_valid && out_avail) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("order", int'(dout), int'(sb.pop_front()));
      end
      delivered++;
    end
  end

  // Drive inputs just after the rising edge; record accepted flits.
  task automatic drive(input bit v, input logic [FW-1:0] d, input bit oa);
    @(posedge clk);
    #1;
    in_valid  = v;
    din       = d;
    out_avail = oa;
    if (rst && v && in_avail) sb.push_back(d);
  endtask

  initial begin
    int lat;
    int d0;
    int exp_lat;
`ifdef EJECT_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_avail", int'(in_avail), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_occ", int'(occ), 0);
    rst = 1'b1;

    // Single flit latency.
    drive(1, 8'hA5, 1);
    drive(0, 8'h00, 1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      drive(0, 8'h00, 1);
      lat++;
    end
    chk("single_latency", lat, exp_lat);
    chk("single_out", int'(dout), 'hA5);
    repeat (2) drive(0, 8'h00, 1);
    chk("single_occ_after", int'(occ), 0);

    // Fill with consumer stalled.
    for (int i = 1; i <= 20; i++) drive(1, FW'(i), 0);
    drive(0, 8'h00, 0);
    chk("fill_accepted", sb.size(), DEPTH + 1);
    chk("fill_in_avail", int'(in_avail), 0);
    chk("fill_occ", int'(occ), DEPTH + 1);
    chk("fill_max", int'(max_occ), DEPTH + 1);
    chk("fill_drop", int'(drop_err), 1);

    // Drain in order.
    d0 = delivered;
    for (int i = 0; i < DEPTH + 3; i++) drive(0, 8'h00, 1);
    chk("drain_count", delivered - d0, DEPTH + 1);
    chk("drain_out_valid", int'(out_valid), 0);
    chk("drain_max", int'(max_occ), DEPTH + 1);

    // Streaming at full rate.
    for (int i = 0; i < 100; i++) begin
      drive(1, FW'(i + 100), 1);
      chk("stream_in_avail", int'(in_avail), 1);
      chk("stream_occ_le2", int'(occ <= 2), 1);
    end
    repeat (4) drive(0, 8'h00, 1);

    // Hold FIFO count at DEPTH-1 with simultaneous push/pop.
    for (int i = 0; i < DEPTH; i++) drive(1, FW'(i + 40), 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, FW'(i + 60), 1);
      chk("wrap_in_avail", int'(in_avail), 1);
      chk("wrap_occ", int'(occ), DEPTH);
    end
    repeat (DEPTH + 3) drive(0, 8'h00, 1);
    chk("wrap_sb_empty", sb.size(), 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) drive(1, FW'(i + 200), 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out", int'(dout), 0);
    chk("arst_in_avail", int'(in_avail), 1);
    chk("arst_occ", int'(occ), 0);
    chk("arst_max", int'(max_occ), 0);
    chk("arst_drop", int'(drop_err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    d0 = delivered;
    drive(1, 8'h3C, 1);
    repeat (5) drive(0, 8'h00, 1);
    chk("arst_new_count", delivered - d0, 1);

    // Random traffic with varying pressure.
    for (int ph = 0; ph < 4; ph++) begin
      int pv;
      int pa;
      pv = 30 + ph * 20;
      pa = 80 - ph * 20;
      for (int i = 0; i < 400; i++) begin
        drive($urandom_range(0, 99) < pv, FW'($urandom), $urandom_range(0, 99) < pa);
      end
    end
    repeat (DEPTH + 4) drive(0, 8'h00, 1);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_out_valid", int'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
